// File: rtl/ft60x_fifo_bridge.sv
// FT600/FT601 245-mode synchronous FIFO master bridging the FT60x pins to a TX valid/ready
// stream and an RX valid-only stream, with bounded bursts and round-robin direction arbitration.
module ft60x_fifo_bridge #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned MAX_BURST  = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  ft_txe_n,
    input  logic                  ft_rxf_n,
    input  logic [DATA_WIDTH-1:0] ft_data_i,
    output logic [DATA_WIDTH-1:0] ft_data_o,
    output logic                  ft_data_oe,
    input  logic [BE_WIDTH-1:0]   ft_be_i,
    output logic [BE_WIDTH-1:0]   ft_be_o,
    output logic                  ft_wr_n,
    output logic                  ft_rd_n,
    output logic                  ft_oe_n,

    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [BE_WIDTH-1:0]   tx_be,
    input  logic                  tx_valid,
    output logic                  tx_ready,

    output logic [DATA_WIDTH-1:0] rx_data,
    output logic [BE_WIDTH-1:0]   rx_be,
    output logic                  rx_valid,
    input  logic                  rx_afull,

    output logic                  busy,
    output logic                  dir_wr
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_BURST);
    localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BURST - 1);

    if (!((DATA_WIDTH == 16) || (DATA_WIDTH == 32))) begin : g_bad_width
        $error("ft60x_fifo_bridge: DATA_WIDTH must be 16 or 32");
    end
    if (BE_WIDTH != DATA_WIDTH / 8) begin : g_bad_be
        $error("ft60x_fifo_bridge: BE_WIDTH must equal DATA_WIDTH/8");
    end
    if ((MAX_BURST < 1) || (MAX_BURST > 4096)) begin : g_bad_burst
        $error("ft60x_fifo_bridge: MAX_BURST must be in 1..4096");
    end

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRdTurn,
        StRead,
        StRdEnd
    } state_e;

    state_e                state_q, state_d;
    logic                  last_wr_q, last_wr_d;
    logic [CntW-1:0]       burst_cnt_q, burst_cnt_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [BE_WIDTH-1:0]   rx_be_q, rx_be_d;
    logic                  rx_valid_q, rx_valid_d;

    logic wr_elig, rd_elig;
    logic burst_open, burst_last;
    logic wr_go, rd_go;

    // Pin-side strobes are decoded from the state register plus the live FT flags so that a
    // flag deasserting stops the transfer in the same cycle.
    always_comb begin
        wr_elig    = ~ft_txe_n & tx_valid;
        rd_elig    = ~ft_rxf_n & ~rx_afull;
        burst_open = (burst_cnt_q < MaxCnt);
        burst_last = (burst_cnt_q == LastCnt);

        tx_ready   = (state_q == StWrite) & ~ft_txe_n & burst_open;
        wr_go      = tx_ready & tx_valid;
        rd_go      = (state_q == StRead) & rd_elig & burst_open;

        ft_wr_n    = ~wr_go;
        ft_rd_n    = ~rd_go;
        ft_oe_n    = ~((state_q == StRdTurn) | (state_q == StRead));
        ft_data_oe = (state_q == StWrite);
        ft_data_o  = tx_data;
        ft_be_o    = tx_be;

        busy       = (state_q != StIdle);
        dir_wr     = (state_q == StWrite);

        rx_data    = rx_data_q;
        rx_be      = rx_be_q;
        rx_valid   = rx_valid_q;
    end

    always_comb begin
        state_d     = state_q;
        last_wr_d   = last_wr_q;
        burst_cnt_d = burst_cnt_q;
        rx_data_d   = rx_data_q;
        rx_be_d     = rx_be_q;
        rx_valid_d  = 1'b0;

        if (rd_go) begin
            rx_data_d  = ft_data_i;
            rx_be_d    = ft_be_i;
            rx_valid_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                burst_cnt_d = '0;
                // On a tie, serve the direction that did not own the previous burst.
                if (wr_elig && (!rd_elig || !last_wr_q)) begin
                    state_d = StWrite;
                end else if (rd_elig) begin
                    state_d = StRdTurn;
                end
            end
            StWrite: begin
                if (wr_go) begin
                    burst_cnt_d = burst_cnt_q + CntW'(1);
                end
                if (!wr_go || burst_last) begin
                    state_d   = StIdle;
                    last_wr_d = 1'b1;
                end
            end
            StRdTurn: begin
                state_d = StRead;
            end
            StRead: begin
                if (rd_go) begin
                    burst_cnt_d = burst_cnt_q + CntW'(1);
                end
                if (!rd_go || burst_last) begin
                    state_d = StRdEnd;
                end
            end
            StRdEnd: begin
                state_d   = StIdle;
                last_wr_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            last_wr_q   <= 1'b0;
            burst_cnt_q <= '0;
            rx_data_q   <= '0;
            rx_be_q     <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_wr_q   <= last_wr_d;
            burst_cnt_q <= burst_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_be_q     <= rx_be_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

endmodule

// File: doc/ft60x_fifo_bridge.md
# ft60x_fifo_bridge

- Parametrised FT600/FT601 245-mode synchronous FIFO master: 16- or 32-bit bus, byte-enable pass-through, bounded bursts, round-robin read/write arbitration.
- Sits between the FT60x pins and the design's A2F/F2A FIFOs. TX is a valid/ready stream; RX is a valid-only stream gated by almost-full.
- All logic on posedge clk (the FT60x clock). The tristate bus is split into _i/_o/_oe for the pad wrapper.

## Interface
- DATA_WIDTH, 32, FT bus width; legal values 16 (FT600) or 32 (FT601). Any other value fails elaboration.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- MAX_BURST, 256, words per burst before re-arbitration; range 1..4096.
- clk  in  1  FT60x clock.
- reset_n  in  1  asynchronous, active-low reset.
- ft_txe_n  in  1  FT60x TX FIFO full when high.
- ft_rxf_n  in  1  FT60x RX FIFO empty when high.
- ft_data_i  in  DATA_WIDTH  bus input.
- ft_data_o  out  DATA_WIDTH  bus output.
- ft_data_oe  out  1  bus (data and be) drive enable.
- ft_be_i  in  BE_WIDTH  byte enables, input.
- ft_be_o  out  BE_WIDTH  byte enables, output.
- ft_wr_n, ft_rd_n, ft_oe_n  out  1 each  FT60x strobes.
- tx_data  in  DATA_WIDTH  write stream data.
- tx_be  in  BE_WIDTH  write stream byte enables.
- tx_valid  in  1  write stream valid.
- tx_ready  out  1  write stream ready.
- rx_data  out  DATA_WIDTH  read stream data.
- rx_be  out  BE_WIDTH  read stream byte enables.
- rx_valid  out  1  read stream valid (one-cycle pulse per word).
- rx_afull  in  1  downstream almost full; downstream must absorb 1 more word after asserting it.
- busy  out  1  state != IDLE.
- dir_wr  out  1  high while in WRITE.

## Operation
- States: IDLE, WRITE, RD_TURN, READ, RD_END. One-hot or binary encoding is free.
- Eligibility and grant (IDLE):
  - wr_elig = ~ft_txe_n & tx_valid; rd_elig = ~ft_rxf_n & ~rx_afull.
  - Only one eligible: go to WRITE or RD_TURN respectively.
  - Both eligible: grant the direction not served last (last_wr flag). After reset last_wr=0, so write wins the first tie.
- burst_cnt clears on leaving IDLE and increments per transferred word. Width is clog2(MAX_BURST+1); it must never wrap.
- WRITE:
  - ft_data_oe=1, ft_data_o=tx_data, ft_be_o=tx_be (combinational).
  - tx_ready = ~ft_txe_n & (burst_cnt < MAX_BURST); ft_wr_n = ~(tx_ready & tx_valid).
  - A word transfers on a posedge with ft_wr_n=0.
  - Exit to IDLE, setting last_wr=1, at the edge where next-cycle eligibility fails: tx_valid low, ft_txe_n high, or burst_cnt reaches MAX_BURST after the transfer.
- RD_TURN: exactly 1 cycle. ft_data_oe=0, ft_oe_n=0, ft_rd_n=1. Then READ.
- READ:
  - ft_oe_n=0; ft_rd_n = ~(~ft_rxf_n & ~rx_afull & burst_cnt < MAX_BURST).
  - A word is captured on a posedge with ft_rd_n=0 and ft_rxf_n=0: rx_data<=ft_data_i, rx_be<=ft_be_i, rx_valid pulses the next cycle.
  - Exit to RD_END when ft_rd_n would be high.
- RD_END: exactly 1 cycle. ft_oe_n=1, ft_data_oe stays 0. Then IDLE with last_wr=0.
- ft_data_oe=1 only in WRITE, so the bus is never driven while ft_oe_n=0.
- Outside WRITE: ft_wr_n=1, tx_ready=0. Outside RD_TURN/READ: ft_oe_n=1. Outside READ: ft_rd_n=1.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, last_wr=0, burst_cnt=0.
  - ft_wr_n=ft_rd_n=ft_oe_n=1, ft_data_oe=0.
  - rx_valid=0, rx_data=0, rx_be=0, busy=0, dir_wr=0.
  - ft_data_o/ft_be_o are don't-care while oe=0.
- Reset mid-burst: strobes return high immediately and the bus is released. A partial burst is not retried.
- Write latency: tx_valid rising with ft_txe_n low gives the first ft_wr_n=0 in the cycle after IDLE, i.e. 1 cycle.
- Read latency: IDLE -> RD_TURN -> READ, so first ft_rd_n=0 is 2 cycles after rd_elig. rx_valid follows the capturing edge by 1 cycle.
- Write throughput is 1 word per clk while unthrottled; read throughput is 1 word per clk after turnaround.
- ft_txe_n rising mid-write: ft_wr_n rises in the same cycle (combinational); no word is lost or duplicated.
- ft_rxf_n rising mid-read: no capture at that edge. rx_afull asserting behaves identically.
- MAX_BURST=1: every burst carries one word and arbitration alternates on a constant tie.

## Test plan
- Write only, DATA_WIDTH=32, 10 words 0x1..0xA, tx_be=0xF, last tx_be=0x3 -> 10 ft_wr_n-low edges carrying the same data and be, in order. busy falls after the 10th.
- Read only, DATA_WIDTH=16, FT model supplies 5 words with ft_rxf_n low -> RD_TURN seen, 5 rx_valid pulses with matching data/be, then RD_END, then IDLE.
- MAX_BURST=4, both sides always eligible -> bursts alternate W4, R4, W4, R4, starting with write; ft_oe_n never low while ft_data_oe=1.
- Mid-burst ft_txe_n pulsed high for 3 cycles -> ft_wr_n high in exactly those cycles; no duplicated or dropped words; re-arbitration follows.
- rx_afull asserted during a read -> at most 1 further rx_valid; then RD_END; read resumes after deassertion with no data loss.
- Reset asserted mid-read -> all strobes high and ft_data_oe=0 asynchronously; the first grant after release is write if tied.
